fetch_frontend: RTL

//   IF stage plus IF/ID pipeline register. Holds the PC and issues reads to a synchronous

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/fetch_skid_buf.sv | 40 ++++
 rtl/fetch_frontend.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: NOP encoding, decode field positions, fetch FSM states.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int RD_LSB  = 7;
   localparam int REG_W   = 5;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_e;

   function automatic logic [REG_W-1:0] rs1_of(input logic [31:0] instr);
      return instr[RS1_LSB +: REG_W];
   endfunction

   function automatic logic [REG_W-1:0] rs2_of(input logic [31:0] instr);
      return instr[RS2_LSB +: REG_W];
   endfunction

   function automatic logic [REG_W-1:0] rd_of(input logic [31:0] instr);
      return instr[RD_LSB +: REG_W];
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding register that parks the response which arrives while
// the front-end is stalled.
module fetch_skid_buf
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_clear,
   input  logic        i_flush,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instr,
   output logic        o_valid,
   output logic [31:0] o_pc,
   output logic [31:0] o_instr
);

   logic        r_valid;
   logic [31:0] r_pc;
   logic [31:0] r_instr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_pc    <= 32'd0;
         r_instr <= NOP_INSTR;
      end else if (i_flush || i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_pc    <= i_pc;
         r_instr <= i_instr;
      end
   end

   assign o_valid = r_valid;
   assign o_pc    = r_pc;
   assign o_instr = r_instr;

endmodule

// File: rtl/fetch_frontend.sv
// IF stage and IF/ID register: PC sequencing against a 1-cycle instruction memory,
// load-use stall with a skid entry, and EX redirect flush.
//
//   state | meaning
//   BOOT  | first cycle after reset, no request issued
//   RUN   | normal fetch; responses go straight into IF/ID
//   HOLD  | stalled with a parked response in the skid buffer
module fetch_frontend
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_i,
   input  logic             redirect_i,
   input  logic [31:0]      redirect_pc_i,
   output logic             imem_req_o,
   output logic [31:0]      imem_addr_o,
   input  logic [31:0]      imem_rdata_i,
   output logic             if_id_valid_o,
   output logic [31:0]      if_id_pc_o,
   output logic [31:0]      if_id_instr_o,
   output logic [4:0]       if_id_rs1_o,
   output logic [4:0]       if_id_rs2_o,
   output logic [4:0]       if_id_rd_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;

   logic [31:0]      r_pc;
   logic             r_pend;
   logic [31:0]      r_pend_pc;
   logic             r_ifid_valid;
   logic [31:0]      r_ifid_pc;
   logic [31:0]      r_ifid_instr;
   logic [CNT_W-1:0] r_stall_cnt;

   logic        w_req;
   logic        w_skid_load;
   logic        w_skid_clear;
   logic        w_skid_v;
   logic [31:0] w_skid_pc;
   logic [31:0] w_skid_instr;
   logic        w_ifid_load;
   logic        w_ifid_valid_d;
   logic [31:0] w_ifid_pc_d;
   logic [31:0] w_ifid_instr_d;

   assign w_req = !rst && !stall_i && !redirect_i && (r_state != ST_BOOT);

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_BOOT;
      else     r_state <= w_state_nxt;
   end

   // Redirect wins over stall in every state and always leaves IF/ID empty.
   always_comb begin
      w_state_nxt    = r_state;
      w_skid_load    = 1'b0;
      w_skid_clear   = 1'b0;
      w_ifid_load    = 1'b0;
      w_ifid_valid_d = 1'b0;
      w_ifid_pc_d    = 32'd0;
      w_ifid_instr_d = NOP_INSTR;
      if (redirect_i) begin
         w_state_nxt = ST_RUN;
         w_ifid_load = 1'b1;
      end else begin
         case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
               if (!stall_i) begin
                  w_ifid_load = 1'b1;
                  if (r_pend) begin
                     w_ifid_valid_d = 1'b1;
                     w_ifid_pc_d    = r_pend_pc;
                     w_ifid_instr_d = imem_rdata_i;
                  end
               end else if (r_pend) begin
                  w_skid_load = 1'b1;
                  w_state_nxt = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!stall_i) begin
                  w_ifid_load    = 1'b1;
                  w_ifid_valid_d = 1'b1;
                  w_ifid_pc_d    = w_skid_pc;
                  w_ifid_instr_d = w_skid_instr;
                  w_skid_clear   = 1'b1;
                  w_state_nxt    = ST_RUN;
               end
            end
            default: w_state_nxt = ST_BOOT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc         <= RESET_PC;
         r_pend       <= 1'b0;
         r_pend_pc    <= 32'd0;
         r_ifid_valid <= 1'b0;
         r_ifid_pc    <= 32'd0;
         r_ifid_instr <= NOP_INSTR;
         r_stall_cnt  <= '0;
      end else begin
         if (redirect_i)  r_pc <= redirect_pc_i;
         else if (w_req)  r_pc <= r_pc + 32'd4;
         r_pend    <= w_req;
         r_pend_pc <= r_pc;
         if (w_ifid_load) begin
            r_ifid_valid <= w_ifid_valid_d;
            r_ifid_pc    <= w_ifid_pc_d;
            r_ifid_instr <= w_ifid_instr_d;
         end
         if (stall_i && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
   end

   fetch_skid_buf u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_skid_load),
      .i_clear (w_skid_clear),
      .i_flush (redirect_i),
      .i_pc    (r_pend_pc),
      .i_instr (imem_rdata_i),
      .o_valid (w_skid_v),
      .o_pc    (w_skid_pc),
      .o_instr (w_skid_instr)
   );

   a_hold_no_pend: assert property (@(posedge clk) (r_state == ST_HOLD) |-> !r_pend);
   // The only request issued with the skid occupied is the one that drains it.
   a_req_skid_empty: assert property (@(posedge clk) imem_req_o |-> (!w_skid_v || w_skid_clear));

   assign imem_req_o    = w_req;
   assign imem_addr_o   = r_pc;
   assign if_id_valid_o = r_ifid_valid;
   assign if_id_pc_o    = r_ifid_pc;
   assign if_id_instr_o = r_ifid_instr;
   assign if_id_rs1_o   = r_ifid_valid ? rs1_of(r_ifid_instr) : 5'd0;
   assign if_id_rs2_o   = r_ifid_valid ? rs2_of(r_ifid_instr) : 5'd0;
   assign if_id_rd_o    = r_ifid_valid ? rd_of(r_ifid_instr)  : 5'd0;
   assign stall_cnt_o   = r_stall_cnt;

endmodule
